// File: rtl/mem_lsu.sv
// mem_lsu: load/store initiator for the word-addressed data RAM.
// Takes one load or store at a time from the core, screens it for illegal
// size codes, out-of-range and (optionally) misaligned addresses, performs
// a single-cycle RAM access and returns the extended load data.
//
// Build option:
//   MEM_LSU_MISALIGN_TRAP_EN  defined   -> misaligned H/W requests are rejected
//                             undefined -> misaligned H/W requests are force-aligned
module mem_lsu #(
  parameter int WORDS = 128
) (
  input  logic        clk,
  input  logic        rst,
  // request channel
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  // response channel
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  // RAM port
  output logic        mem_r,
  output logic [3:0]  mem_w,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

`ifdef MEM_LSU_MISALIGN_TRAP_EN
  localparam bit MISALIGN_TRAP = 1'b1;
`else
  localparam bit MISALIGN_TRAP = 1'b0;
`endif

  // Word-index limit, sized to the word-index field of a byte address.
  localparam logic [29:0] WORDS_W = 30'(WORDS);

  // Access size encoded in funct3[1:0].
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Any reason to reject the request before touching the RAM.
  function automatic logic req_error(input logic        we,
                                     input logic [2:0]  f3,
                                     input logic [31:0] addr);
    logic illegal;
    logic out_of_range;
    logic misaligned;
    illegal      = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
                   (we && f3[2]);
    out_of_range = (addr[31:2] >= WORDS_W);
    misaligned   = ((f3[1:0] == SZ_H) && addr[0]) ||
                   ((f3[1:0] == SZ_W) && (addr[1:0] != 2'b00));
    return illegal || out_of_range || (MISALIGN_TRAP && misaligned);
  endfunction

  // Byte-lane write mask. Halves select lanes by addr[1] only and words use
  // all lanes, so a misaligned request that was not trapped is force-aligned.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3,
                                           input logic [1:0] a);
    logic [3:0] m;
    case (f3[1:0])
      SZ_B:    m = 4'b0001 << a;
      SZ_H:    m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Store data replicated across every lane the access might hit, so the
  // RAM only needs the lane mask to pick the right bytes.
  function automatic logic [31:0] replicate(input logic [2:0]  f3,
                                            input logic [31:0] wd);
    logic [31:0] r;
    case (f3[1:0])
      SZ_B:    r = {4{wd[7:0]}};
      SZ_H:    r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  // Select the addressed byte/half from the RAM word and extend it.
  // funct3[2] = 1 selects zero extension, 0 sign extension.
  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  a,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(rd >> {a, 3'b000});
    h = a[1] ? rd[31:16] : rd[15:0];
    case (f3[1:0])
      SZ_B:    r = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_H:    r = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q,      state_d;
  logic        we_q,         we_d;
  logic [2:0]  funct3_q,     funct3_d;
  logic [31:0] addr_q,       addr_d;
  logic        req_ready_q,  req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q,   resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        mem_r_q,      mem_r_d;
  logic [3:0]  mem_w_q,      mem_w_d;
  logic [31:0] mem_wdata_q,  mem_wdata_d;

  logic accept;
  logic accept_err;

  assign accept     = (state_q == IDLE) && req_valid && req_ready_q;
  assign accept_err = req_error(req_we, req_funct3, req_addr);

  // Next-state and next-output computation for the IDLE/ACCESS/RESP sequence.
  always_comb begin
    // NOTE: every _d defaults to its _q first, so no branch can leave a
    // signal unassigned and infer a latch.
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    mem_r_d      = 1'b0;
    mem_w_d      = 4'b0000;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d        = req_we;
          funct3_d    = req_funct3;
          addr_d      = req_addr;
          mem_wdata_d = replicate(req_funct3, req_wdata);
          req_ready_d = 1'b0;
          if (accept_err) begin
            // Rejected: answer straight away without touching the RAM.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else begin
            state_d = ACCESS;
            mem_r_d = ~req_we;
            mem_w_d = req_we ? lane_mask(req_funct3, req_addr[1:0]) : 4'b0000;
          end
        end
      end

      ACCESS: begin
        // Strobes drop back to zero; load data is captured on this edge.
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = we_q ? 32'h0 : load_extend(funct3_q, addr_q[1:0], mem_rdata);
      end

      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          req_ready_d  = 1'b1;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = 32'h0;
        end
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // All state and registered outputs; reset also drops the write mask at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= 32'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_r_q      <= 1'b0;
      mem_w_q      <= 4'b0000;
      mem_wdata_q  <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_r_q      <= mem_r_d;
      mem_w_q      <= mem_w_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_r      = mem_r_q;
  assign mem_w      = mem_w_q;
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store initiator for the single-cycle SoC's word-addressed data RAM. Accepts one load or store request at a time from the core over a valid/ready handshake. Drives the RAM's read strobe, byte-lane write mask, address and write data, and returns sign- or zero-extended load data on a response handshake. Misaligned, illegal and out-of-range requests are screened before any memory access.

## Interface
- WORDS, 128, RAM depth in 32-bit words; requests with addr[31:2] >= WORDS are out of range
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  request rejected, no memory access performed
- mem_r  out  1  RAM read strobe
- mem_w  out  4  RAM byte-lane write mask, bit i = byte lane i
- mem_addr  out  32  RAM byte address
- mem_wdata  out  32  RAM write data, lane-replicated
- mem_rdata  in  32  RAM read data (combinational from mem_addr/mem_r)

## Operation
- States: IDLE, ACCESS, RESP. Reset state IDLE.
- req_ready = 1 only in IDLE. Handshake when req_valid & req_ready at a rising edge: latch we, funct3, addr, wdata.
- Error check at acceptance:
  - illegal funct3: 011, 110, 111, or store with funct3[2]=1
  - out of range: addr[31:2] >= WORDS
  - misaligned: see Configuration
  - On error: IDLE -> RESP with resp_err=1, resp_rdata=0; no ACCESS cycle.
  - Otherwise: IDLE -> ACCESS.
- ACCESS lasts exactly one cycle, then -> RESP.
  - Load: mem_r=1, mem_w=0.
  - Store: mem_r=0, mem_w = B: 1<<addr[1:0]; H: 0011 or 1100 by addr[1]; W: 1111.
  - mem_wdata replication: B {4{wdata[7:0]}}, H {2{wdata[15:0]}}, W wdata.
- Load capture at end of ACCESS: select byte by addr[1:0], half by addr[1]; funct3[2]=0 sign-extends, 1 zero-extends.
- RESP: resp_valid=1, outputs held stable until resp_ready; on handshake -> IDLE.
- No request is accepted in the RESP->IDLE edge; minimum spacing between accepts is 3 cycles for a valid access and 2 cycles for an error.
- Outside ACCESS: mem_r=0, mem_w=0. mem_addr is driven with the latched address word-aligned (low 2 bits 0) in all states.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_r=0, mem_w=0, mem_addr=0, mem_wdata=0.
- Accept at edge N. ACCESS occupies cycle N..N+1. The RAM commits the store on the falling edge within that cycle. Load data is sampled at edge N+1. resp_valid rises after N+1.
- Error path: resp_valid rises after edge N.
- rst asserted mid-ACCESS forces mem_w=0 immediately; if rst precedes the falling edge, no write occurs. Any pending response is discarded.
- mem_r and mem_w are driven from registered state only, never combinationally from req_* inputs.

## Configuration
- MEM_LSU_MISALIGN_TRAP_EN defined:
  - H with addr[0]=1, or W with addr[1:0]!=0, is an error.
  - resp_err=1, no access.
- Undefined:
  - Misaligned requests are force-aligned: H ignores addr[0], W ignores addr[1:0].
  - The access proceeds normally with resp_err=0.
- Illegal-funct3 and out-of-range checks are always present.

## Test plan
- Store W addr 0x10 wdata 0xDEADBEEF, then load W 0x10 -> mem_w=1111 for one cycle; resp_rdata=0xDEADBEEF, resp_err=0.
- Store B addr 0x13 wdata 0x000000A5 over 0x11223344; load B 0x13 -> mem_w=1000, mem_wdata=0xA5A5A5A5. Load B returns 0xFFFFFFA5; load BU returns 0x000000A5; load W returns 0xA5223344.
- Load H addr 0x12 from 0x8001_7FFF -> resp_rdata=0xFFFF8001; load HU -> 0x00008001.
- Load W addr 0x11:
  - With macro: resp_err=1, resp_rdata=0, mem_r never asserts.
  - Without macro: data of word 0x10 is returned, resp_err=0.
- Request with addr = WORDS*4, and a request with funct3=011 -> both give resp_err=1 after one cycle with no mem_r/mem_w activity. resp_valid holds for 5 cycles with resp_ready=0; req_ready stays 0 throughout.
- Assert rst during ACCESS of a store, before the falling edge -> memory word is unchanged. After reset, req_ready=1 and resp_valid=0.
